// File: rtl/xadc_sweep_sequencer.sv
// xadc_sweep_sequencer
//   Sweeps XADC auxiliary channels VAUX0..VAUX12 over the DRP after each
//   end-of-conversion pulse and collects the results in a shadow bank. On
//   the next falling edge of display vsync, the whole shadow bank is copied
//   into the display bank in a single cycle, so display reads never see a
//   partially updated sweep.
//
//   Optional build macro: SEQ_AVG4_EN -- each channel is read four times
//   and the stored value is the average of the four 12-bit samples. If any
//   of the four reads times out, the channel stores 12'hFFF.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous, active-low reset
//   eoc         XADC end-of-conversion pulse; starts a sweep from IDLE
//   vs          display vsync; its falling edge marks the frame boundary
//   drp_den     DRP enable, one cycle per read
//   drp_dwe     DRP write enable, tied low
//   drp_daddr   DRP address, 7'h10 + channel while drp_den is high, else 0
//   drp_drdy    DRP read-data strobe
//   drp_do      DRP read data; the sample is drp_do[15:4]
//   rd_ch       display channel select
//   rd_data     display-bank value for rd_ch, one cycle later (0 for 13..15)
//   frame_upd   one-cycle pulse when the display bank is refreshed
//   timeout_err sticky DRP timeout flag, cleared only by reset

module xadc_sweep_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        eoc,
  input  logic        vs,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [6:0]  drp_daddr,
  input  logic        drp_drdy,
  input  logic [15:0] drp_do,
  input  logic [3:0]  rd_ch,
  output logic [11:0] rd_data,
  output logic        frame_upd,
  output logic        timeout_err
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, STORE, HOLD} state_t;

  localparam logic [3:0] LAST_CH = 4'd12;

  state_t      state, state_nx;
  logic [3:0]  ch;
  logic [7:0]  wcnt;
  logic        vs_q;
  logic        vs_fall;
  logic        last_read;
  logic [11:0] store_val;
  logic [11:0] shadow [13];
  logic [11:0] disp   [13];
  logic        unused_do_lsb;

`ifdef SEQ_AVG4_EN
  logic [1:0]  rep;
  logic [13:0] acc;
  logic        tflag;
`else
  logic [11:0] sample;
`endif

  assign vs_fall       = vs_q & ~vs;
  assign unused_do_lsb = ^drp_do[3:0];

`ifdef SEQ_AVG4_EN
  assign last_read = (rep == 2'd3);
  assign store_val = tflag ? 12'hFFF : acc[13:2];
`else
  assign last_read = 1'b1;
  assign store_val = sample;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (eoc) state_nx = REQ;
      REQ:   state_nx = WAIT;
      // wcnt == 255 is the 256th WAIT cycle; a drdy there is still accepted
      WAIT:  if (drp_drdy || wcnt == 8'hFF) state_nx = STORE;
      STORE: if (last_read && ch == LAST_CH) state_nx = HOLD;
             else                            state_nx = REQ;
      HOLD:  if (vs_fall) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    drp_dwe   = 1'b0;
    drp_den   = (state == REQ);
    drp_daddr = (state == REQ) ? (7'h10 + {3'b000, ch}) : '0;
  end

  // Datapath: channel/wait counters, sample capture, shadow and display banks
  always_ff @(posedge clk) begin
    if (!rst) begin
      ch          <= '0;
      wcnt        <= '0;
      vs_q        <= 1'b0;
      frame_upd   <= 1'b0;
      timeout_err <= 1'b0;
      rd_data     <= '0;
`ifdef SEQ_AVG4_EN
      rep         <= '0;
      acc         <= '0;
      tflag       <= 1'b0;
`else
      sample      <= '0;
`endif
      for (int unsigned i = 0; i < 13; i++) begin
        shadow[i] <= '0;
        disp[i]   <= '0;
      end
    end else begin
      vs_q      <= vs;
      frame_upd <= 1'b0;
      case (state)
        IDLE: if (eoc) begin
          ch    <= '0;
`ifdef SEQ_AVG4_EN
          rep   <= '0;
          acc   <= '0;
          tflag <= 1'b0;
`endif
        end
        REQ: wcnt <= '0;
        WAIT: begin
          wcnt <= wcnt + 8'd1;
          if (drp_drdy) begin
`ifdef SEQ_AVG4_EN
            acc    <= acc + {2'b00, drp_do[15:4]};
`else
            sample <= drp_do[15:4];
`endif
          end else if (wcnt == 8'hFF) begin
            timeout_err <= 1'b1;
`ifdef SEQ_AVG4_EN
            tflag  <= 1'b1;
`else
            sample <= '1;
`endif
          end
        end
        STORE: begin
          if (last_read) begin
            shadow[ch] <= store_val;
            if (ch != LAST_CH) ch <= ch + 4'd1;
`ifdef SEQ_AVG4_EN
            rep   <= '0;
            acc   <= '0;
            tflag <= 1'b0;
          end else begin
            rep <= rep + 2'd1;
`endif
          end
        end
        HOLD: if (vs_fall) begin
          for (int unsigned i = 0; i < 13; i++) disp[i] <= shadow[i];
          frame_upd <= 1'b1;
        end
        default: ;
      endcase
      rd_data <= (rd_ch < 4'd13) ? disp[rd_ch] : '0;
    end
  end

endmodule

// File: tb/tb_xadc_sweep_sequencer.sv
module tb_xadc_sweep_sequencer;

`ifdef SEQ_AVG4_EN
  localparam int REPS = 4;
`else
  localparam int REPS = 1;
`endif

  logic        clk;
  logic        rst;
  logic        eoc;
  logic        vs;
  logic        drp_den;
  logic        drp_dwe;
  logic [6:0]  drp_daddr;
  logic        drp_drdy;
  logic [15:0] drp_do;
  logic [3:0]  rd_ch;
  logic [11:0] rd_data;
  logic        frame_upd;
  logic        timeout_err;

  xadc_sweep_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .eoc         (eoc),
    .vs          (vs),
    .drp_den     (drp_den),
    .drp_dwe     (drp_dwe),
    .drp_daddr   (drp_daddr),
    .drp_drdy    (drp_drdy),
    .drp_do      (drp_do),
    .rd_ch       (rd_ch),
    .rd_data     (rd_data),
    .frame_upd   (frame_upd),
    .timeout_err (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vecs = 0;
  int errs = 0;
  logic [11:0] shadow_exp [13];
  logic [11:0] disp_exp   [13];
  logic        terr_exp = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_ch = 4'(i);
      tick;
      chk($sformatf("%s_rd%0d", tag, i), 32'(rd_data), (i < 13) ? 32'(disp_exp[i]) : 32'd0);
    end
  endtask

  // Behavioural DRP responder plus sweep expectation.
  // mode 0: value ch+1 (ch2 under averaging: 100+rep), latency 3
  // mode 1: random values, random latency 1..20; with a dropped channel,
  //         ch3 answers on the very last allowed WAIT cycle (latency 256)
  task automatic sweep(input int mode, input int drop_ch, input int mid_ch, input int abort_ch);
    int den_n, pend, cyc, last_den, exp_gap, upd_seen, tail, abort_stage, lat, c, r;
    bit done, tail_on, mid_restore;
    logic [11:0] pend_val, val;
    int sums [13];
    den_n = 0; pend = 0; cyc = 0; last_den = 0; exp_gap = 0; upd_seen = 0;
    tail = 0; abort_stage = 0; done = 0; tail_on = 0; mid_restore = 0;
    pend_val = '0;
    for (int i = 0; i < 13; i++) sums[i] = 0;
    eoc = 1'b1;
    while (!done) begin
      tick;
      cyc++;
      eoc = 1'b0;
      drp_drdy = 1'b0;
      drp_do = 16'($urandom);
      if (mid_restore) begin vs = 1'b1; mid_restore = 0; end
      if (frame_upd) upd_seen++;
      if (abort_stage == 2) begin
        rst = 1'b1;
        drp_drdy = 1'b1;
        done = 1;
      end else if (abort_stage == 1) begin
        rst = 1'b0;
        abort_stage = 2;
      end else begin
        if (tail_on && drop_ch != 12 && $urandom_range(0, 1) == 1) drp_drdy = 1'b1;
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            drp_drdy = 1'b1;
            drp_do = {pend_val, 4'($urandom)};
          end
        end
        if (drp_den) begin
          c = den_n / REPS;
          r = den_n % REPS;
          if (den_n > 0) chk("den_gap", 32'(cyc - last_den), 32'(exp_gap));
          chk("daddr", 32'(drp_daddr), 32'(7'h10 + 7'(c)));
          if (mode == 0) val = (REPS == 4 && c == 2) ? 12'(100 + r) : 12'(c + 1);
          else           val = 12'($urandom_range(0, 4095));
          if (c < 13) sums[c] += int'(val);
          if (c == abort_ch && r == 0) begin
            abort_stage = 1;
          end else if (c == drop_ch) begin
            exp_gap = 258;
          end else begin
            if (mode == 0)                          lat = 3;
            else if (drop_ch >= 0 && c == 3)        lat = 256;
            else                                    lat = $urandom_range(1, 20);
            pend = lat;
            pend_val = val;
            exp_gap = lat + 2;
            // strobe during the REQ cycle must be ignored
            if ($urandom_range(0, 1) == 1) drp_drdy = 1'b1;
          end
          if (c == mid_ch && r == 0) begin
            vs = 1'b0;
            eoc = 1'b1;
            mid_restore = 1;
          end
          last_den = cyc;
          den_n++;
        end
        if (tail_on) begin
          tail--;
          if (tail <= 0) done = 1;
        end else if (den_n >= 13 * REPS && pend == 0) begin
          tail_on = 1;
          tail = (drop_ch == 12) ? 260 * REPS + 5 : 5;
        end
      end
      if (cyc > 30000) begin
        vecs++;
        errs++;
        $error("FAIL sweep_budget: observed %0d cycles expected completion", cyc);
        done = 1;
      end
    end
    drp_drdy = 1'b0;
    vs = 1'b1;
    chk("frame_upd_during_sweep", 32'(upd_seen), 32'd0);
    if (abort_ch < 0) begin
      chk("den_total", 32'(den_n), 32'(13 * REPS));
      for (int i = 0; i < 13; i++)
        shadow_exp[i] = (i == drop_ch) ? 12'hFFF : 12'(sums[i] / REPS);
      if (drop_ch >= 0) terr_exp = 1'b1;
    end else begin
      for (int i = 0; i < 13; i++) begin
        shadow_exp[i] = '0;
        disp_exp[i] = '0;
      end
      terr_exp = 1'b0;
    end
  endtask

  task automatic frame(input bit with_eoc);
    int dens;
    tick;
    vs = 1'b0;
    if (with_eoc) eoc = 1'b1;
    tick;
    eoc = 1'b0;
    chk("frame_upd_pulse", 32'(frame_upd), 32'd1);
    for (int i = 0; i < 13; i++) disp_exp[i] = shadow_exp[i];
    dens = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (i == 0) chk("frame_upd_drop", 32'(frame_upd), 32'd0);
      if (drp_den) dens++;
    end
    chk("no_den_after_copy", 32'(dens), 32'd0);
    vs = 1'b1;
  endtask

  initial begin
    int dens;
    rst = 1'b0; eoc = 1'b0; vs = 1'b0; drp_drdy = 1'b0; drp_do = '0; rd_ch = '0;
    for (int i = 0; i < 13; i++) begin shadow_exp[i] = '0; disp_exp[i] = '0; end
    repeat (3) tick;
    chk("rst_den", 32'(drp_den), 32'd0);
    chk("rst_daddr", 32'(drp_daddr), 32'd0);
    chk("rst_dwe", 32'(drp_dwe), 32'd0);
    chk("rst_frame_upd", 32'(frame_upd), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    rst = 1'b1;
    repeat (3) begin
      tick;
      chk("vs_low_release", 32'(frame_upd), 32'd0);
    end
    vs = 1'b1;
    read_all("post_rst");

    // directed sweep: latency 3, data ch+1
    sweep(0, -1, -1, -1);
    read_all("hold_old_bank");
    chk("timeout_clean", 32'(timeout_err), 32'(terr_exp));
    frame(0);
    rd_ch = 4'd5; tick;
    chk("rd_ch5", 32'(rd_data), 32'(disp_exp[5]));
    rd_ch = 4'd13; tick;
    chk("rd_ch13", 32'(rd_data), 32'd0);
    read_all("copy1");

    // random sweep, ch7 never answers, vs edge and eoc in mid-sweep
    sweep(1, 7, 4, -1);
    chk("timeout_set", 32'(timeout_err), 32'(terr_exp));
    read_all("untorn");
    frame(1);
    read_all("copy2");

    // random sweep without timeouts; flag must stay set
    sweep(1, -1, -1, -1);
    frame(0);
    read_all("copy3");
    chk("timeout_sticky", 32'(timeout_err), 32'(terr_exp));

    // reset while waiting on ch9, late drdy afterwards
    sweep(1, -1, -1, 9);
    dens = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (drp_den) dens++;
    end
    chk("abort_no_den", 32'(dens), 32'd0);
    chk("abort_timeout", 32'(timeout_err), 32'(terr_exp));
    read_all("abort");

    sweep(0, -1, -1, -1);
    frame(0);
    read_all("final");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
